edge_bbox_scanner: RTL



---
 rtl/vision_pkg.sv | 16 +
 rtl/edge_bbox_scanner_if.sv | 32 +++
 rtl/edge_bbox_scanner_raster_addr_gen.sv | 50 +++++
 rtl/edge_bbox_scanner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared vision-pipeline definitions.
// Holds the default image geometry, the field widths used on the edge-map
// read path and bounding-box outputs, the scanner state encoding, and the
// bit position that marks an edge pixel in an edge-map word.
package vision_pkg;
  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_W       = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int CNT_W        = 19;
  localparam int EDGE_BIT     = 0;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, COMMIT, DONE} state_t;
endpackage

// File: rtl/edge_bbox_scanner_if.sv
// Handshake, edge-map read bus and result bus of the edge bounding-box scanner.
//   start            level request from the previous pass / controller
//   done             results valid for the current start
//   edge_data        edge BRAM read data (bit EDGE_BIT = edge)
//   edge_memory_addr edge BRAM read address, y*WIDTH+x
//   edge_count/found/x_min/x_max/y_min/y_max  scan results
// master: the side that drives start and returns read data.
// slave:  the scanner itself.
interface edge_bbox_scanner_if;
  import vision_pkg::*;

  logic              start;
  logic              done;
  logic [3:0]        edge_data;
  logic [ADDR_W-1:0] edge_memory_addr;
  logic [CNT_W-1:0]  edge_count;
  logic              found;
  logic [X_W-1:0]    x_min;
  logic [X_W-1:0]    x_max;
  logic [Y_W-1:0]    y_min;
  logic [Y_W-1:0]    y_max;

  modport master (
    output start, edge_data,
    input  done, edge_memory_addr, edge_count, found, x_min, x_max, y_min, y_max
  );

  modport slave (
    input  start, edge_data,
    output done, edge_memory_addr, edge_count, found, x_min, x_max, y_min, y_max
  );
endinterface

// File: rtl/edge_bbox_scanner_raster_addr_gen.sv
// Raster address generator: walks x 0..WIDTH-1 then y+1, one pixel per
// enabled cycle, with the linear address y*WIDTH+x kept as a running counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous return to pixel (0,0); wins over en
//   en          advance one pixel
//   x, y, addr  current pixel coordinates and linear address
//   last        current pixel is (WIDTH-1, HEIGHT-1)
module raster_addr_gen #(
  parameter int WIDTH  = vision_pkg::WIDTH,
  parameter int HEIGHT = vision_pkg::HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  output logic [vision_pkg::X_W-1:0]    x,
  output logic [vision_pkg::Y_W-1:0]    y,
  output logic [vision_pkg::ADDR_W-1:0] addr,
  output logic                          last
);
  import vision_pkg::*;

  logic x_end;
  logic y_end;

  assign x_end = (x == X_W'(WIDTH - 1));
  assign y_end = (y == Y_W'(HEIGHT - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (en) begin
      // End of row wraps straight into the next row: no idle cycle.
      addr <= last ? '0 : addr + ADDR_W'(1);
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end
endmodule

// File: rtl/edge_bbox_scanner.sv
// Edge bounding-box scanner.
// Once start is raised, reads the whole edge map in raster order (one address
// per cycle), counts edge pixels and tracks their bounding box, then
// publishes the results and holds done until start is dropped.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         edge_bbox_scanner_if.slave: start/done handshake, edge BRAM
//               read port, edge_count/found/x_min/x_max/y_min/y_max results
// Published results only change on commit or reset; an aborted scan leaves
// the previous results in place.
module edge_bbox_scanner #(
  parameter int WIDTH        = vision_pkg::WIDTH,
  parameter int HEIGHT       = vision_pkg::HEIGHT,
  parameter int READ_LATENCY = vision_pkg::READ_LATENCY
) (
  input logic                clk,
  input logic                rst_n,
  edge_bbox_scanner_if.slave bus
);
  import vision_pkg::*;

  state_t state, state_nxt;

  logic [X_W-1:0]    gen_x;
  logic [Y_W-1:0]    gen_y;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  logic              gen_en;
  logic              gen_clr;
  logic              scan_run;
  logic              commit;
  logic              acc_en;

  logic [X_W-1:0]          x_p [READ_LATENCY];
  logic [Y_W-1:0]          y_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] head_vld;

  logic [CNT_W-1:0] cnt_w;
  logic [X_W-1:0]   xmin_w, xmax_w;
  logic [Y_W-1:0]   ymin_w, ymax_w;

  raster_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (gen_clr),
    .en   (gen_en),
    .x    (gen_x),
    .y    (gen_y),
    .addr (gen_addr),
    .last (gen_last)
  );

  assign bus.edge_memory_addr = gen_addr;
  assign bus.done             = (state == DONE);

  // Every stage except the tail; the tail is consumed on the same edge that
  // leaves DRAIN, so only the earlier stages need to be empty.
  always_comb begin
    head_vld                   = vld_p;
    head_vld[READ_LATENCY-1]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gen_en    = 1'b0;
    gen_clr   = 1'b1;
    scan_run  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SCAN;
      end
      SCAN: begin
        if (!bus.start) begin
          state_nxt = IDLE;
        end else begin
          gen_en    = 1'b1;
          gen_clr   = 1'b0;
          scan_run  = 1'b1;
          if (gen_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.start) begin
          state_nxt = IDLE;
        end else begin
          scan_run  = 1'b1;
          if (head_vld == '0) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        if (!bus.start) begin
          state_nxt = IDLE;
        end else begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc_en = scan_run && vld_p[READ_LATENCY-1] && bus.edge_data[EDGE_BIT];

  // ---- p0..pN: issued coordinates delayed to line up with edge_data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (!scan_run) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == SCAN);
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    x_p[0] <= gen_x;
    y_p[0] <= gen_y;
    for (int i = 1; i < READ_LATENCY; i++) begin
      x_p[i] <= x_p[i-1];
      y_p[i] <= y_p[i-1];
    end
  end

  // ---- accumulate at the pipeline tail ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_w  <= '0;
      xmin_w <= '0;
      xmax_w <= '0;
      ymin_w <= '0;
      ymax_w <= '0;
    end else if (!(scan_run || commit)) begin
      // Idle or aborted: reload so the first edge pixel always wins both compares.
      cnt_w  <= '0;
      xmin_w <= X_W'(WIDTH - 1);
      xmax_w <= '0;
      ymin_w <= Y_W'(HEIGHT - 1);
      ymax_w <= '0;
    end else if (acc_en) begin
      cnt_w <= cnt_w + CNT_W'(1);
      if (x_p[READ_LATENCY-1] < xmin_w) xmin_w <= x_p[READ_LATENCY-1];
      if (x_p[READ_LATENCY-1] > xmax_w) xmax_w <= x_p[READ_LATENCY-1];
      if (y_p[READ_LATENCY-1] < ymin_w) ymin_w <= y_p[READ_LATENCY-1];
      if (y_p[READ_LATENCY-1] > ymax_w) ymax_w <= y_p[READ_LATENCY-1];
    end
  end

  // ---- commit to the published result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.edge_count <= '0;
      bus.found      <= 1'b0;
      bus.x_min      <= '0;
      bus.x_max      <= '0;
      bus.y_min      <= '0;
      bus.y_max      <= '0;
    end else if (commit) begin
      bus.edge_count <= cnt_w;
      bus.found      <= (cnt_w != '0);
      if (cnt_w != '0) begin
        bus.x_min <= xmin_w;
        bus.x_max <= xmax_w;
        bus.y_min <= ymin_w;
        bus.y_max <= ymax_w;
      end else begin
        bus.x_min <= '0;
        bus.x_max <= '0;
        bus.y_min <= '0;
        bus.y_max <= '0;
      end
    end
  end
endmodule
